// File: rtl/btb_ctrl.sv
// btb_ctrl: sequences the single-port BTB SRAM between fetch lookups and branch-resolve updates.
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop pending updates and the in-flight lookup, then re-clear the table
//   lkp_*                lookup request/ready, one-cycle response (hit, target)
//   upd_*                update request/ready with pc, target, invalidate flag
//   init_busy            table clear sweep in progress
//   sram_*               1RW SRAM port (csb/web active low, dout valid the cycle after a read)
module btb_ctrl #(
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned DATA_W     = 56,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              lkp_req,
    input  logic [31:0]       lkp_pc,
    output logic              lkp_rdy,
    output logic              lkp_resp_valid,
    output logic              lkp_hit,
    output logic [31:0]       lkp_target,
    input  logic              upd_req,
    input  logic [31:0]       upd_pc,
    input  logic [31:0]       upd_target,
    input  logic              upd_inval,
    output logic              upd_rdy,
    output logic              init_busy,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [IDX_W-1:0]  sram_addr0,
    output logic [DATA_W-1:0] sram_din0,
    input  logic [DATA_W-1:0] sram_dout0
);

    localparam int unsigned TAG_W = 29 - IDX_W;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {S_INIT, S_RUN} state_e;

    // pc is kept as pc[30:2]: pc[31] is intentionally not part of the tag
    typedef struct packed {
        logic [28:0] pc;
        logic [29:0] tgt;
        logic        inval;
    } upd_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    upd_t             fifo0_q, fifo0_d, fifo1_q, fifo1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             resp_q;
    logic [TAG_W-1:0] tag_q;
    logic             byp_hit_q, byp_inval_q, byp_hit_d, byp_inval_d;
    logic [29:0]      byp_tgt_q, byp_tgt_d;

    logic             do_wr, do_rd, upd_acc;
    logic [1:0]       wr_idx;
    logic             m0, m1, sram_hit, hit_raw;
    logic [29:0]      tgt_raw;
    upd_t             upd_new;
    logic             unused_bits;

    assign unused_bits = ^{lkp_pc[31], lkp_pc[1:0], upd_pc[31], upd_pc[1:0], upd_target[1:0]};
    assign upd_new     = '{pc: upd_pc[30:2], tgt: upd_target[31:2], inval: upd_inval};

    // SRAM issue arbitration: sweep in INIT, else pending write vs. lookup read
    always_comb begin
        sram_csb0  = 1'b1;
        sram_web0  = 1'b1;
        sram_addr0 = '0;
        sram_din0  = '0;
        lkp_rdy    = 1'b0;
        upd_rdy    = 1'b0;
        do_wr      = 1'b0;
        do_rd      = 1'b0;
        if (rst_n) begin
            if (state_q == S_INIT) begin
                sram_csb0  = 1'b0;
                sram_web0  = 1'b0;
                sram_addr0 = init_cnt_q;
            end else if (!flush) begin
                upd_rdy = (cnt_q != 2'd2);
                if ((cnt_q != 2'd0) && (!lkp_req || (starve_q == CNT_W'(STARVE_MAX)))) begin
                    do_wr      = 1'b1;
                    sram_csb0  = 1'b0;
                    sram_web0  = 1'b0;
                    sram_addr0 = fifo0_q.pc[IDX_W-1:0];
                    sram_din0  = {~fifo0_q.inval, fifo0_q.pc[28:IDX_W],
                                  fifo0_q.inval ? 30'd0 : fifo0_q.tgt};
                end else begin
                    lkp_rdy = 1'b1;
                    if (lkp_req) begin
                        do_rd      = 1'b1;
                        sram_csb0  = 1'b0;
                        sram_addr0 = lkp_pc[IDX_W+1:2];
                    end
                end
            end
        end
    end

    // Forwarding from entries already queued at the start of this cycle; youngest wins
    always_comb begin
        m0          = (cnt_q != 2'd0) && (fifo0_q.pc == lkp_pc[30:2]);
        m1          = (cnt_q == 2'd2) && (fifo1_q.pc == lkp_pc[30:2]);
        byp_hit_d   = m0 | m1;
        byp_inval_d = m1 ? fifo1_q.inval : fifo0_q.inval;
        byp_tgt_d   = m1 ? fifo1_q.tgt   : fifo0_q.tgt;
    end

    // Next state for FIFO, starvation counter and INIT sweep
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        fifo0_d    = fifo0_q;
        fifo1_d    = fifo1_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        upd_acc    = upd_req & upd_rdy;
        wr_idx     = 2'(cnt_q - 2'(do_wr));
        if (flush) begin
            state_d    = S_INIT;
            init_cnt_d = '0;
            cnt_d      = 2'd0;
            starve_d   = '0;
        end else if (state_q == S_INIT) begin
            init_cnt_d = IDX_W'(init_cnt_q + IDX_W'(1));
            if (&init_cnt_q) begin
                state_d = S_RUN;
            end
        end else begin
            if (do_wr) begin
                fifo0_d  = fifo1_q;
                starve_d = '0;
            end else if (do_rd && (cnt_q != 2'd0) && (starve_q != CNT_W'(STARVE_MAX))) begin
                starve_d = CNT_W'(starve_q + CNT_W'(1));
            end
            if (upd_acc) begin
                if (wr_idx == 2'd0) begin
                    fifo0_d = upd_new;
                end else begin
                    fifo1_d = upd_new;
                end
            end
            cnt_d = 2'(wr_idx + 2'(upd_acc));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            fifo0_q     <= '0;
            fifo1_q     <= '0;
            cnt_q       <= 2'd0;
            starve_q    <= '0;
            resp_q      <= 1'b0;
            tag_q       <= '0;
            byp_hit_q   <= 1'b0;
            byp_inval_q <= 1'b0;
            byp_tgt_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            fifo0_q    <= fifo0_d;
            fifo1_q    <= fifo1_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            resp_q     <= do_rd;
            if (do_rd) begin
                tag_q       <= lkp_pc[30:IDX_W+2];
                byp_hit_q   <= byp_hit_d;
                byp_inval_q <= byp_inval_d;
                byp_tgt_q   <= byp_tgt_d;
            end
        end
    end

    // Response: SRAM data is only valid this cycle, so hit/target are formed from dout directly
    always_comb begin
        sram_hit = sram_dout0[DATA_W-1] && (sram_dout0[DATA_W-2 -: TAG_W] == tag_q);
        if (byp_hit_q) begin
            hit_raw = ~byp_inval_q;
            tgt_raw = byp_tgt_q;
        end else begin
            hit_raw = sram_hit;
            tgt_raw = sram_dout0[29:0];
        end
        lkp_resp_valid = rst_n & resp_q & ~flush;
        lkp_hit        = lkp_resp_valid & hit_raw;
        lkp_target     = lkp_hit ? {tgt_raw, 2'b00} : 32'd0;
        init_busy      = ~rst_n | (state_q == S_INIT);
    end

endmodule

// File: tb/tb_btb_ctrl.sv
// Scoreboard bench for btb_ctrl with a behavioural 1RW SRAM model.
module tb_btb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, flush, lkp_req, upd_req, upd_inval;
    logic [31:0] lkp_pc, upd_pc, upd_target, lkp_target;
    logic        lkp_rdy, lkp_resp_valid, lkp_hit, upd_rdy, init_busy;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_addr0;
    logic [55:0] sram_din0, sram_dout0;
    logic [55:0] mem [16];

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    btb_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .lkp_req(lkp_req), .lkp_pc(lkp_pc), .lkp_rdy(lkp_rdy),
        .lkp_resp_valid(lkp_resp_valid), .lkp_hit(lkp_hit), .lkp_target(lkp_target),
        .upd_req(upd_req), .upd_pc(upd_pc), .upd_target(upd_target), .upd_inval(upd_inval),
        .upd_rdy(upd_rdy), .init_busy(init_busy),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    // SRAM model; starts full of valid all-ones garbage so the clear sweep matters
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 56'hFF_FFFF_FFFF_FFFF;
        sram_dout0 = '0;
    end
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0;
            else            sram_dout0 <= mem[sram_addr0];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented response against the oldest expectation
    always @(negedge clk) begin
        logic [32:0] e;
        if (lkp_resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 64'(lkp_target), 64'(33'h1_FFFF_FFFF));
            end else begin
                e = exp_q.pop_front();
                chk("lkp_hit", 64'(lkp_hit), 64'(e[32]));
                chk("lkp_target", 64'(lkp_target), 64'(e[31:0]));
            end
        end
    end

    // One cycle of stimulus; rdy is the expected lkp_rdy, (h,t) the expected response,
    // cw/wa/wd an expected SRAM write this cycle
    task automatic cyc(input logic lr, input logic [31:0] lp,
                       input logic ur, input logic [31:0] up, input logic [31:0] ut, input logic ui,
                       input logic rdy, input logic h, input logic [31:0] t,
                       input logic cw, input logic [3:0] wa, input logic [55:0] wd);
        lkp_req = lr; lkp_pc = lp;
        upd_req = ur; upd_pc = up; upd_target = ut; upd_inval = ui;
        @(negedge clk);
        if (lr) begin
            chk("lkp_rdy", 64'(lkp_rdy), 64'(rdy));
            if (rdy) exp_q.push_back({h, t});
        end
        if (ur) chk("upd_rdy", 64'(upd_rdy), 64'd1);
        if (cw) begin
            chk("wr_en", 64'({sram_csb0, sram_web0}), 64'd0);
            chk("wr_addr", 64'(sram_addr0), 64'(wa));
            chk("wr_data", 64'(sram_din0), 64'(wd));
        end
        @(posedge clk); #1;
        lkp_req = 1'b0; upd_req = 1'b0; upd_inval = 1'b0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic init_sweep();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_en", 64'({sram_csb0, sram_web0}), 64'd0);
            chk("init_addr", 64'(sram_addr0), 64'(i));
            chk("init_din", 64'(sram_din0), 64'd0);
            chk("init_busy", 64'(init_busy), 64'd1);
            chk("init_upd_rdy", 64'(upd_rdy), 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("init_done", 64'(init_busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; lkp_req = 1'b0; upd_req = 1'b0; upd_inval = 1'b0;
        lkp_pc = '0; upd_pc = '0; upd_target = '0;

        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_csb", 64'(sram_csb0), 64'd1);
        chk("rst_lkp_rdy", 64'(lkp_rdy), 64'd0);
        chk("rst_upd_rdy", 64'(upd_rdy), 64'd0);
        chk("rst_resp", 64'({lkp_resp_valid, lkp_hit}), 64'd0);
        chk("rst_target", 64'(lkp_target), 64'd0);
        chk("rst_busy", 64'(init_busy), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // clear sweep, then a lookup whose tag matches the pre-reset garbage must miss
        init_sweep();
        cyc(1, 32'h7FFF_FFC0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // update written to SRAM, then looked up from SRAM
        cyc(0, 0, 1, 32'h0000_1040, 32'h0000_2000, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0, 56'h80_0010_4000_0800);
        idle();
        cyc(1, 32'h0000_1040, 0, 0, 0, 0, 1, 1, 32'h0000_2000, 0, 0, 0);
        // same index, other tag
        cyc(1, 32'h0000_2040, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // starvation limit: 4 reads win, 5th cycle the pending write goes out
        cyc(1, 32'h100, 1, 32'h0000_5010, 32'h0000_6000, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 4'd4, 56'h80_0050_0000_1800);
        cyc(1, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // bypass from a queued update while lookups stream
        cyc(1, 32'h100, 1, 32'h0000_3008, 32'h0000_4000, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'h0000_3008, 0, 0, 0, 0, 1, 1, 32'h0000_4000, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd2, 56'h80_0030_0000_1000);
        cyc(1, 32'h0000_3008, 0, 0, 0, 0, 1, 1, 32'h0000_4000, 0, 0, 0);

        // update enqueued in the same cycle as the lookup is not forwarded
        cyc(1, 32'h0000_7020, 1, 32'h0000_7020, 32'h0000_8000, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd8, 56'h80_0070_0000_2000);
        cyc(1, 32'h0000_7020, 0, 0, 0, 0, 1, 1, 32'h0000_8000, 0, 0, 0);

        // invalidating update forwarded as a miss, then written with valid=0
        cyc(1, 32'h100, 1, 32'h0000_3008, 32'h0000_4000, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'h0000_3008, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd2, 56'h00_0030_0000_0000);
        cyc(1, 32'h0000_3008, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // two queued updates to the same pc: youngest is forwarded, both drain in order
        cyc(1, 32'h100, 1, 32'h0000_3008, 32'h1111_0000, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'h100, 1, 32'h0000_3008, 32'h2222_0000, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'h0000_3008, 0, 0, 0, 0, 1, 1, 32'h2222_0000, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd2, 56'h80_0030_0444_4000);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd2, 56'h80_0030_0888_8000);
        cyc(1, 32'h0000_3008, 0, 0, 0, 0, 1, 1, 32'h2222_0000, 0, 0, 0);

        // flush with a full FIFO and a lookup in flight
        cyc(1, 32'h100, 1, 32'h0000_9000, 32'h0000_A000, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'h100, 1, 32'h0000_9004, 32'h0000_B000, 0, 1, 0, 0, 0, 0, 0);
        lkp_req = 1'b1; lkp_pc = 32'h0000_9004;
        @(negedge clk);
        chk("flush_pre_rdy", 64'(lkp_rdy), 64'd1);
        chk("fifo_full", 64'(upd_rdy), 64'd0);
        @(posedge clk); #1;
        lkp_req = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush_resp", 64'(lkp_resp_valid), 64'd0);
        chk("flush_upd_rdy", 64'(upd_rdy), 64'd0);
        chk("flush_lkp_rdy", 64'(lkp_rdy), 64'd0);
        chk("flush_no_op", 64'(sram_csb0), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        init_sweep();
        @(negedge clk);
        chk("fifo_dropped", 64'(sram_csb0), 64'd1);
        @(posedge clk); #1;
        cyc(1, 32'h0000_9000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'h0000_9004, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'h0000_1040, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        idle();
        idle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
